// File: rtl/ptp_rtc_pkg.sv
// Shared widths and constants for the PTP real-time clock.
// Time is kept as seconds plus ns in 1/256 ns units. Increments use an 8.32 ns format.
package ptp_rtc_pkg;
   localparam int NS_W   = 38;
   localparam int SEC_W  = 48;
   localparam int PER_W  = 40;
   localparam int FRAC_W = 24;
   localparam int INC_W  = PER_W + 1;
   localparam int STEP_W = INC_W - FRAC_W;
   localparam int CNT_W  = 32;

   localparam logic [NS_W-1:0] MODULO_DEFAULT = 38'd256_000_000_000;

   function automatic logic [INC_W-1:0] sext_per(input logic [PER_W-1:0] v);
      return {v[PER_W-1], v};
   endfunction
endpackage

// File: rtl/rtc_frac_ds.sv
// Residual accumulator for the bits of the increment below 1/256 ns.
// The carry-out adds one extra 1/256 ns LSB to the ns step.
module rtc_frac_ds
   import ptp_rtc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic [FRAC_W-1:0] frac_i,
   output logic              carry_o
);
   logic [FRAC_W-1:0] resid_q, resid_d;
   logic [FRAC_W:0]   sum;

   always_comb begin
      sum     = {1'b0, resid_q} + {1'b0, frac_i};
      carry_o = sum[FRAC_W];
      resid_d = en_i ? sum[FRAC_W-1:0] : resid_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) resid_q <= '0;
      else      resid_q <= resid_d;
   end
endmodule

// File: rtl/ptp_rtc.sv
// Free-running PTP time-of-day counter with period trim, a bounded phase slew and a direct load.
// The ns register rolls over at time_acc_modulo (1/256 ns units) and borrows from seconds.
module ptp_rtc
   import ptp_rtc_pkg::*;
#(
   parameter logic [NS_W-1:0] time_acc_modulo = MODULO_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              time_ld,
   input  logic [NS_W-1:0]   time_reg_ns_in,
   input  logic [SEC_W-1:0]  time_reg_sec_in,
   input  logic              period_ld,
   input  logic [PER_W-1:0]  period_in,
   input  logic              adj_ld,
   input  logic [CNT_W-1:0]  adj_ld_data,
   input  logic [PER_W-1:0]  period_adj,
   output logic              adj_ld_done,
   output logic [NS_W-1:0]   time_reg_ns,
   output logic [SEC_W-1:0]  time_reg_sec,
   output logic [31:0]       time_ptp_ns,
   output logic [SEC_W-1:0]  time_ptp_sec
);
   logic [PER_W-1:0] period_q, period_d;
   logic [PER_W-1:0] adj_q, adj_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [NS_W-1:0]  ns_q, ns_d;
   logic [SEC_W-1:0] sec_q, sec_d;

   logic [INC_W-1:0] inc;
   logic             carry;
   logic [NS_W+1:0]  ns_sum;

   rtc_frac_ds u_frac (
      .clk     (clk),
      .rst     (rst),
      .en_i    (!time_ld),
      .frac_i  (inc[FRAC_W-1:0]),
      .carry_o (carry)
   );

   always_comb begin
      inc = {1'b0, period_q} + ((cnt_q != '0) ? sext_per(adj_q) : '0);
      // ns_sum is signed with two guard bits: bit 39 set means the step went below zero.
      ns_sum = {2'b00, ns_q}
             + {{(NS_W+2-STEP_W){inc[INC_W-1]}}, inc[INC_W-1:FRAC_W]}
             + {{(NS_W+1){1'b0}}, carry};
   end

   always_comb begin
      period_d = period_ld ? period_in : period_q;
      adj_d    = adj_ld ? period_adj : adj_q;
      cnt_d    = adj_ld ? adj_ld_data : ((cnt_q != '0) ? cnt_q - 1'b1 : cnt_q);
      done_d   = adj_ld ? (adj_ld_data == '0) : (cnt_q == CNT_W'(1));
      ns_d     = ns_sum[NS_W-1:0];
      sec_d    = sec_q;
      if (time_ld) begin
         ns_d  = time_reg_ns_in;
         sec_d = time_reg_sec_in;
      end else if (ns_sum[NS_W+1]) begin
         ns_d  = ns_sum[NS_W-1:0] + time_acc_modulo;
         sec_d = sec_q - 1'b1;
      end else if (ns_sum >= {2'b00, time_acc_modulo}) begin
         ns_d  = ns_sum[NS_W-1:0] - time_acc_modulo;
         sec_d = sec_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         period_q <= '0;
         adj_q    <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         ns_q     <= '0;
         sec_q    <= '0;
      end else begin
         period_q <= period_d;
         adj_q    <= adj_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         ns_q     <= ns_d;
         sec_q    <= sec_d;
      end
   end

   assign adj_ld_done  = done_q;
   assign time_reg_ns  = ns_q;
   assign time_reg_sec = sec_q;
   assign time_ptp_ns  = {2'b00, ns_q[NS_W-1:8]};
   assign time_ptp_sec = sec_q;
endmodule

// File: tb/tb_ptp_rtc.sv
// Bench for ptp_rtc: directed scenarios plus random traffic against a time-line reference model.
// The model keeps time as one signed count of 1/256 ns plus a sub-LSB residual.
module tb_ptp_rtc;
   localparam longint MOD = 256000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        time_ld = 1'b0;
   logic [37:0] time_reg_ns_in = '0;
   logic [47:0] time_reg_sec_in = '0;
   logic        period_ld = 1'b0;
   logic [39:0] period_in = '0;
   logic        adj_ld = 1'b0;
   logic [31:0] adj_ld_data = '0;
   logic [39:0] period_adj = '0;
   logic        adj_ld_done;
   logic [37:0] time_reg_ns;
   logic [47:0] time_reg_sec;
   logic [31:0] time_ptp_ns;
   logic [47:0] time_ptp_sec;

   ptp_rtc #(.time_acc_modulo(38'(MOD))) dut (
      .clk             (clk),
      .rst             (rst),
      .time_ld         (time_ld),
      .time_reg_ns_in  (time_reg_ns_in),
      .time_reg_sec_in (time_reg_sec_in),
      .period_ld       (period_ld),
      .period_in       (period_in),
      .adj_ld          (adj_ld),
      .adj_ld_data     (adj_ld_data),
      .period_adj      (period_adj),
      .adj_ld_done     (adj_ld_done),
      .time_reg_ns     (time_reg_ns),
      .time_reg_sec    (time_reg_sec),
      .time_ptp_ns     (time_ptp_ns),
      .time_ptp_sec    (time_ptp_sec)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: tod is total time in 1/256 ns, resid the sub-LSB remainder (2^-32 ns units)
   longint tod_m = 0, resid_m = 0, period_m = 0, adj_m = 0, cnt_m = 0;
   bit     done_m = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic longint cur_tod();
      return longint'(time_reg_sec) * MOD + longint'(time_reg_ns);
   endfunction

   task automatic model_edge();
      longint inc, v, a;
      if (!rst) begin
         tod_m = 0; resid_m = 0; period_m = 0; adj_m = 0; cnt_m = 0; done_m = 1'b0;
         return;
      end
      a   = $signed(period_adj);
      inc = period_m + ((cnt_m != 0) ? adj_m : 0);
      if (time_ld) begin
         tod_m = longint'(time_reg_sec_in) * MOD + longint'(time_reg_ns_in);
      end else begin
         v       = resid_m + inc;
         resid_m = v & 64'hFF_FFFF;
         tod_m   = tod_m + (v >>> 24);
      end
      done_m = adj_ld ? (adj_ld_data == 0) : (cnt_m == 1);
      if (adj_ld) begin
         cnt_m = longint'(adj_ld_data);
         adj_m = a;
      end else if (cnt_m != 0) begin
         cnt_m = cnt_m - 1;
      end
      if (period_ld) period_m = longint'(period_in);
   endtask

   task automatic cyc();
      longint es, en;
      @(posedge clk);
      model_edge();
      #1;
      es = tod_m / MOD;
      en = tod_m % MOD;
      chk("ns",      64'(time_reg_ns),  64'(en));
      chk("sec",     64'(time_reg_sec), 64'(es) & 64'hFFFF_FFFF_FFFF);
      chk("ptp_ns",  64'(time_ptp_ns),  64'(en >> 8));
      chk("ptp_sec", 64'(time_ptp_sec), 64'(es) & 64'hFFFF_FFFF_FFFF);
      chk("done",    64'(adj_ld_done),  64'(done_m));
      time_ld = 1'b0; period_ld = 1'b0; adj_ld = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic load_time(input longint ns, input longint sec);
      time_ld = 1'b1;
      time_reg_ns_in  = 38'(ns * 256);
      time_reg_sec_in = 48'(sec);
   endtask

   task automatic start_slew(input int n, input logic [39:0] adj);
      adj_ld = 1'b1;
      adj_ld_data = 32'(n);
      period_adj = adj;
   endtask

   longint t0;
   int     pulses;

   initial begin
      // reset, then frozen time with period 0
      rst = 1'b0;
      run(3);
      rst = 1'b1;
      run(20);
      chk("frozen_ns", 64'(time_reg_ns), 64'd0);

      // +8 ns per cycle, rollover on the 13th increment
      period_ld = 1'b1; period_in = 40'h08_0000_0000;
      load_time(900, 10);
      cyc();
      run(13);
      chk("roll_ns",  64'(time_reg_ns),  64'(4 * 256));
      chk("roll_sec", 64'(time_reg_sec), 64'd11);

      // +8 ns slew for 100 cycles: 800 ns extra, one done pulse
      t0 = cur_tod();
      start_slew(100, 40'h08_0000_0000);
      cyc();
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (adj_ld_done) pulses++;
      end
      chk("slew_delta", 64'(cur_tod() - t0), 64'((101 * 8 + 800) * 256));
      cyc();
      if (adj_ld_done) pulses++;
      run(3);
      chk("slew_pulses", 64'(pulses), 64'd1);

      // -5 ns slew: +3 ns per cycle
      t0 = cur_tod();
      start_slew(100, 40'hFB_0000_0000);
      cyc();
      run(100);
      chk("neg5_delta", 64'(cur_tod() - t0), 64'((101 * 8 - 500) * 256));
      run(4);

      // -16 ns slew: -8 ns per cycle across zero, seconds borrow
      load_time(50, 5);
      cyc();
      start_slew(100, 40'hF0_0000_0000);
      cyc();
      run(10);
      chk("borrow_sec", 64'(time_reg_sec), 64'd4);
      run(95);

      // fractional period: residual carries every 8th cycle
      period_ld = 1'b1; period_in = 40'h08_1020_0000;
      cyc();
      run(40);

      // simultaneous load and slew, restart mid-slew, zero-length slew
      load_time(100, 20);
      start_slew(10, 40'h01_0000_0000);
      cyc();
      run(5);
      start_slew(20, 40'h02_0000_0000);
      cyc();
      run(25);
      start_slew(0, 40'h05_0000_0000);
      cyc();
      chk("zero_done", 64'(adj_ld_done), 64'd1);
      run(4);

      // random traffic
      load_time(0, 3000);
      cyc();
      for (int i = 0; i < 1500; i++) begin
         int     r, an;
         longint av;
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            time_ld = 1'b1;
            time_reg_ns_in  = 38'($urandom_range(0, int'(MOD) - 1));
            time_reg_sec_in = 48'($urandom_range(1000, 5000));
         end
         if (r >= 3 && r < 8) begin
            period_ld = 1'b1;
            period_in = {8'($urandom_range(1, 20)), 32'($urandom)};
         end
         if ((r >= 6 && r < 12) || r == 50) begin
            an = int'($urandom_range(0, 40)) - 20;
            av = longint'(an) * 64'sh1_0000_0000 + longint'($urandom);
            adj_ld = 1'b1;
            adj_ld_data = 32'($urandom_range(0, 30));
            period_adj = av[39:0];
         end
         if (r == 99) rst = 1'b0;
         cyc();
         if (!rst) begin
            rst = 1'b1;
            load_time(500, 4000);
            period_ld = 1'b1; period_in = 40'h07_8000_0000;
            cyc();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ptp_rtc.md
# ptp_rtc

Free-running PTP real-time clock holding time-of-day as seconds plus nanoseconds with 8 sub-ns fraction bits, advanced every clock cycle by a programmable period. Supports a direct time load, frequency trim through the period, and a time-limited phase slew (extra signed increment for N cycles). Sits under the 1588 timestamp logic and feeds time to timestamp capture units and CPU readback.

## Interface
- time_acc_modulo, 38'd256_000_000_000: ns-register rollover in 1/256 ns units (1e9 ns); benches may shrink it, e.g. 256000 = 1000 ns "second".
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- time_ld  in  1  load ToD this cycle.
- time_reg_ns_in  in  38  [37:8] ns, [7:0] ns fraction.
- time_reg_sec_in  in  48  seconds.
- period_ld  in  1  load period this cycle.
- period_in  in  40  per-cycle increment, unsigned: [39:32] ns, [31:0] fraction.
- adj_ld  in  1  start slew.
- adj_ld_data  in  32  slew length in cycles.
- period_adj  in  40  signed two's-complement extra increment, same 8.32 format.
- adj_ld_done  out  1  one-cycle pulse when slew ends.
- time_reg_ns  out  38  ns.frac register.
- time_reg_sec  out  48  seconds register.
- time_ptp_ns  out  32  {2'b0, time_reg_ns[37:8]}.
- time_ptp_sec  out  48  equals time_reg_sec.

## Operation
- Reset (rst=0 at edge): period, ns, sec, fraction accumulator, slew counter, slew value, adj_ld_done all 0. Period 0 means time holds still until period_ld.
- Per-cycle increment inc = period + (slew_cnt != 0 ? sign-extended period_adj : 0), signed 41-bit, 8.32 format.
- Delta-sigma: inc[23:0] added to 24-bit residual accumulator; its carry-out adds 1 LSB (1/256 ns) to the ns step. ns step = inc[40:24] + carry (signed, 1/256 ns units).
- ns_next = time_reg_ns + step. If ns_next >= time_acc_modulo: subtract modulo, sec+1. If ns_next < 0: add modulo, sec-1. |step| < modulo guaranteed by the user.
- time_ld: ns/sec take input values; no increment that cycle; residual accumulator unchanged. Loaded ns must be < modulo (not checked).
- period_ld: period register updated; used from next cycle. Residual kept.
- adj_ld: slew_cnt <= adj_ld_data, slew value <= period_adj; restarts any running slew. Each cycle with slew_cnt != 0 applies slew and decrements. adj_ld_done pulses the cycle after slew_cnt reaches 0 from 1; adj_ld_data=0 gives done pulse next cycle, no slew applied.
- Priority same cycle: time_ld over increment; period_ld and adj_ld independent, all may coincide.

## Timing
- All outputs registered; load at edge k visible after edge k.
- Increment applied at every edge without time_ld; step uses period/slew registered before that edge.
- Slew of N cycles changes time by N*period_adj relative to nominal.
- time_ptp_* are combinational copies of registers (zero extra latency).

## Structure
- Shared package: widths (NS_W=38, SEC_W=48, PER_W=40, FRAC_W=24), default modulo constant.
- One sub-module natural: rtc_frac_ds (24-bit residual accumulator, carry out). Rest (period/slew regs, counter, ns/sec update) in top.

## Test plan
- Reset with rst=0 -> all outputs 0; period=0 keeps time frozen for 20 cycles.
- modulo=256000, period 0x08_00000000, load ns=900, sec=10 -> ns +8/cycle; 13th cycle after load ns=4, sec=11.
- adj_ld, data=100, period_adj=+8 ns -> ns +16/cycle for exactly 100 cycles, adj_ld_done 1-cycle pulse after, total +800 ns vs nominal.
- period_adj=0xFB_00000000 (-5) for 100 cycles -> +3 ns/cycle; period_adj=0xF0 (-16) -> -8 ns/cycle, crossing 0 borrows: ns wraps to modulo-x, sec decrements.
- period 0x08_10200000 -> fraction +0x10 per cycle plus extra LSB every 8th cycle (residual 0x200000 carries).
- Simultaneous time_ld and adj_ld -> time loaded, slew starts next cycle; adj_ld during slew restarts count.
